// File: rtl/tft_pkg.sv
// tft_pkg: shared arbiter state encoding and requester index constants.
package tft_pkg;
  typedef enum logic [1:0] {
    TFT_ARB_IDLE  = 2'd0,
    TFT_ARB_OWN   = 2'd1,
    TFT_ARB_DRAIN = 2'd2
  } tft_arb_state_e;
  localparam int TFT_REQ_INIT = 0;
  localparam int TFT_REQ_WIN  = 1;
  localparam int TFT_REQ_PIX  = 2;
  localparam int TFT_N_REQ    = 3;
endpackage

// File: rtl/tft_arb_pick.sv
// tft_arb_pick: one-hot winner select; TFT_ARB_RR_EN selects round-robin, else fixed priority.
module tft_arb_pick
  import tft_pkg::*;
#(
  parameter int N_REQ = TFT_N_REQ,
  parameter int PW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    last,
  output logic [N_REQ-1:0] gnt
);
`ifdef TFT_ARB_RR_EN
  // Nearest index after the last owner is written last, so it wins.
  always_comb begin
    gnt = '0;
    for (int k = N_REQ; k >= 1; k--)
      for (int i = 0; i < N_REQ; i++)
        if (req[i] && i == (int'(last) + k) % N_REQ) gnt = N_REQ'(1) << i;
  end
`else
  logic unused_last;
  assign unused_last = ^last;
  assign gnt = req & (~req + 1'b1);
`endif
endmodule

// File: rtl/tft_arbiter.sv
// tft_arbiter: shares the TFT byte transmitter between requesters; TFT_ARB_RR_EN enables round-robin.
module tft_arbiter
  import tft_pkg::*;
#(
  parameter int N_REQ     = TFT_N_REQ,
  parameter int DRAIN_MIN = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req,
  input  logic [N_REQ-1:0]     req_transmit,
  input  logic [N_REQ-1:0]     req_dc,
  input  logic [8*N_REQ-1:0]   req_data,
  output logic [N_REQ-1:0]     grant,
  output logic [N_REQ-1:0]     req_busy,
  input  logic                 tft_busy,
  output logic                 tft_transmit,
  output logic                 tft_dc,
  output logic [7:0]           tft_data,
  output logic                 drop_err
);
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(DRAIN_MIN + 2);
  tft_arb_state_e state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d, pick;
  logic [PW-1:0] last_q, last_d, pick_idx;
  logic [CW-1:0] cnt_q, cnt_d;
  logic tft_transmit_q, tft_transmit_d, tft_dc_q, tft_dc_d, drop_err_q, drop_err_d;
  logic [7:0] tft_data_q, tft_data_d, own_data;
  logic own_dc, owner_stb, fwd, drop, drain_done;

  tft_arb_pick #(.N_REQ(N_REQ), .PW(PW)) u_pick (.req(req), .last(last_q), .gnt(pick));

  always_comb begin
    own_data = '0;
    own_dc = 1'b0;
    pick_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_q[i]) begin
        own_data = req_data[8*i +: 8];
        own_dc = req_dc[i];
      end
      if (pick[i]) pick_idx = PW'(i);
    end
  end

  // A strobe is forwarded only from the owner, in OWN, with the transmitter free and no byte in flight.
  assign owner_stb  = |(req_transmit & grant_q);
  assign fwd        = state_q == TFT_ARB_OWN && owner_stb && !tft_busy && !tft_transmit_q;
  assign drop       = |(req_transmit & ~grant_q) || (owner_stb && !fwd);
  assign drain_done = !tft_busy && !tft_transmit_q && ({1'b0, cnt_q} + 1'b1) >= (CW+1)'(DRAIN_MIN);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d = last_q;
    cnt_d = '0;
    unique case (state_q)
      TFT_ARB_IDLE: if (|req) begin
        state_d = TFT_ARB_OWN;
        grant_d = pick;
        last_d = pick_idx;
      end
      TFT_ARB_OWN: if (!(|(req & grant_q))) state_d = TFT_ARB_DRAIN;
      TFT_ARB_DRAIN: begin
        cnt_d = (cnt_q == CW'(DRAIN_MIN)) ? cnt_q : cnt_q + 1'b1;
        if (drain_done) begin
          state_d = TFT_ARB_IDLE;
          grant_d = '0;
        end
      end
      default: state_d = TFT_ARB_IDLE;
    endcase
    tft_transmit_d = fwd;
    tft_dc_d = fwd ? own_dc : tft_dc_q;
    tft_data_d = fwd ? own_data : tft_data_q;
    drop_err_d = drop_err_q | drop;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= TFT_ARB_IDLE;
      grant_q <= '0;
      last_q <= PW'(N_REQ - 1);
      cnt_q <= '0;
      tft_transmit_q <= 1'b0;
      tft_dc_q <= 1'b0;
      tft_data_q <= 8'h00;
      drop_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q <= last_d;
      cnt_q <= cnt_d;
      tft_transmit_q <= tft_transmit_d;
      tft_dc_q <= tft_dc_d;
      tft_data_q <= tft_data_d;
      drop_err_q <= drop_err_d;
    end
  end

  assign grant = grant_q;
  assign req_busy = {N_REQ{tft_busy}} | ~grant_q;
  assign tft_transmit = tft_transmit_q;
  assign tft_dc = tft_dc_q;
  assign tft_data = tft_data_q;
  assign drop_err = drop_err_q;
endmodule

// File: tb/tb_tft_arbiter.sv
// tb_tft_arbiter: directed-vector bench for tft_arbiter (fixed priority, or round-robin under TFT_ARB_RR_EN).
module tb_tft_arbiter;
  logic clk = 1'b0, rst = 1'b0, tft_busy = 1'b0;
  logic [2:0] req = '0, req_transmit = '0, req_dc = '0;
  logic [23:0] req_data = '0;
  logic [2:0] grant, req_busy;
  logic tft_transmit, tft_dc, drop_err;
  logic [7:0] tft_data;
  int n_vec = 0, n_err = 0;

  always #5 clk = ~clk;

  tft_arbiter dut (
    .clk(clk), .rst(rst), .req(req), .req_transmit(req_transmit), .req_dc(req_dc),
    .req_data(req_data), .grant(grant), .req_busy(req_busy), .tft_busy(tft_busy),
    .tft_transmit(tft_transmit), .tft_dc(tft_dc), .tft_data(tft_data), .drop_err(drop_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req = '0; req_transmit = '0; req_dc = '0; req_data = '0; tft_busy = 1'b0;
    rst = 1'b0;
    tick(); tick();
    rst = 1'b1;
  endtask

  task automatic release_all();
    req = '0; req_transmit = '0;
    repeat (3) tick();
  endtask

  task automatic test_reset();
    tick(); tick();
    n_vec++; if (grant !== 3'b000) begin n_err++; $display("FAIL reset_grant: got %b want 000", grant); end
    n_vec++; if (tft_transmit !== 1'b0) begin n_err++; $display("FAIL reset_tx: got %b want 0", tft_transmit); end
    n_vec++; if (tft_data !== 8'h00 || tft_dc !== 1'b0) begin n_err++; $display("FAIL reset_data: got %h/%b want 00/0", tft_data, tft_dc); end
    n_vec++; if (drop_err !== 1'b0) begin n_err++; $display("FAIL reset_drop: got %b want 0", drop_err); end
    n_vec++; if (req_busy !== 3'b111) begin n_err++; $display("FAIL reset_busy: got %b want 111", req_busy); end
    rst = 1'b1;
    tick();
    n_vec++; if (grant !== 3'b000) begin n_err++; $display("FAIL idle_grant: got %b want 000", grant); end
  endtask

  task automatic test_single();
    req = 3'b001;
    tick();
    n_vec++; if (grant !== 3'b001) begin n_err++; $display("FAIL single_grant: got %b want 001", grant); end
    n_vec++; if (req_busy !== 3'b110) begin n_err++; $display("FAIL single_busy: got %b want 110", req_busy); end
    req_transmit = 3'b001; req_dc = 3'b000; req_data[7:0] = 8'h2A;
    tick();
    req_transmit = '0;
    n_vec++; if (tft_transmit !== 1'b1 || tft_data !== 8'h2A || tft_dc !== 1'b0) begin n_err++; $display("FAIL single_fwd: got tx=%b data=%h dc=%b want 1/2a/0", tft_transmit, tft_data, tft_dc); end
    tick();
    n_vec++; if (tft_transmit !== 1'b0) begin n_err++; $display("FAIL single_pulse: got %b want 0", tft_transmit); end
    n_vec++; if (drop_err !== 1'b0) begin n_err++; $display("FAIL single_drop: got %b want 0", drop_err); end
    req = '0;
    tick(); tick();
    n_vec++; if (grant !== 3'b001) begin n_err++; $display("FAIL single_drain_hold: got %b want 001", grant); end
    tick();
    n_vec++; if (grant !== 3'b000) begin n_err++; $display("FAIL single_idle: got %b want 000", grant); end
  endtask

  task automatic test_contention();
    req = 3'b110;
    tick();
    n_vec++; if (grant !== 3'b010) begin n_err++; $display("FAIL prio_110: got %b want 010", grant); end
    req = 3'b101;
    tick();
    n_vec++; if (grant !== 3'b010) begin n_err++; $display("FAIL prio_no_preempt: got %b want 010", grant); end
    tick(); tick();
    n_vec++; if (grant !== 3'b000) begin n_err++; $display("FAIL prio_gap: got %b want 000", grant); end
    tick();
    n_vec++; if (grant !== 3'b001) begin n_err++; $display("FAIL prio_101: got %b want 001", grant); end
    release_all();
  endtask

  task automatic test_rr();
    logic [2:0] exp_rr [4];
    exp_rr = '{3'b001, 3'b010, 3'b100, 3'b001};
    do_reset();
    req = 3'b111;
    for (int j = 0; j < 4; j++) begin
      for (int t = 0; t < 10 && grant === 3'b000; t++) tick();
      n_vec++; if (grant !== exp_rr[j]) begin n_err++; $display("FAIL rr_order%0d: got %b want %b", j, grant, exp_rr[j]); end
      req_transmit = grant; req_data = 24'hA5A5A5;
      tick();
      req_transmit = '0;
      req = req & ~grant;
      tick();
      req = 3'b111;
      for (int t = 0; t < 10 && grant !== 3'b000; t++) tick();
    end
    release_all();
  endtask

  task automatic test_illegal();
    req = 3'b001;
    tick();
    req_transmit = 3'b010; req_dc = 3'b010; req_data[15:8] = 8'h55;
    tick();
    req_transmit = '0;
    n_vec++; if (tft_transmit !== 1'b0) begin n_err++; $display("FAIL illegal_tx: got %b want 0", tft_transmit); end
    n_vec++; if (drop_err !== 1'b1) begin n_err++; $display("FAIL illegal_drop: got %b want 1", drop_err); end
    tick(); tick();
    n_vec++; if (drop_err !== 1'b1) begin n_err++; $display("FAIL illegal_sticky: got %b want 1", drop_err); end
    release_all();
  endtask

  task automatic test_back_to_back();
    do_reset();
    req = 3'b001;
    tick();
    req_transmit = 3'b001; req_dc = 3'b001; req_data[7:0] = 8'h11;
    tick();
    n_vec++; if (tft_transmit !== 1'b1 || tft_data !== 8'h11 || tft_dc !== 1'b1) begin n_err++; $display("FAIL b2b_first: got tx=%b data=%h dc=%b want 1/11/1", tft_transmit, tft_data, tft_dc); end
    req_data[7:0] = 8'h22;
    tick();
    req_transmit = '0;
    n_vec++; if (tft_transmit !== 1'b0 || tft_data !== 8'h11) begin n_err++; $display("FAIL b2b_second: got tx=%b data=%h want 0/11", tft_transmit, tft_data); end
    n_vec++; if (drop_err !== 1'b1) begin n_err++; $display("FAIL b2b_drop: got %b want 1", drop_err); end
    release_all();
  endtask

  task automatic test_drain_hold();
    req = 3'b001;
    tick();
    tft_busy = 1'b1; req = 3'b010;
    repeat (10) tick();
    n_vec++; if (grant !== 3'b001) begin n_err++; $display("FAIL drain_held: got %b want 001", grant); end
    n_vec++; if (req_busy !== 3'b111) begin n_err++; $display("FAIL drain_busy: got %b want 111", req_busy); end
    tft_busy = 1'b0;
    tick();
    n_vec++; if (grant !== 3'b000) begin n_err++; $display("FAIL drain_idle: got %b want 000", grant); end
    tick();
    n_vec++; if (grant !== 3'b010) begin n_err++; $display("FAIL drain_next: got %b want 010", grant); end
    release_all();
  endtask

  task automatic test_async_reset();
    do_reset();
    req = 3'b001;
    tick();
    req_transmit = 3'b011; req_data = 24'h00_77_33;
    tick();
    req_transmit = '0;
    n_vec++; if (tft_transmit !== 1'b1 || drop_err !== 1'b1) begin n_err++; $display("FAIL async_pre: got tx=%b drop=%b want 1/1", tft_transmit, drop_err); end
    #2 rst = 1'b0;
    #1;
    n_vec++; if (grant !== 3'b000 || tft_transmit !== 1'b0 || drop_err !== 1'b0) begin n_err++; $display("FAIL async_clear: got grant=%b tx=%b drop=%b want 000/0/0", grant, tft_transmit, drop_err); end
    tick();
    rst = 1'b1; req = '0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
`ifdef TFT_ARB_RR_EN
    test_rr();
`else
    test_contention();
`endif
    test_illegal();
    test_back_to_back();
    test_drain_hold();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
